fft2d_pass_sequencer: RTL and testbench
=======================================

// Module: fft2d_pass_sequencer
// PURPOSE
//  Sequences one full 2D FFT over the 32-unit 1D FFT array: a row pass, a transpose turnaround gap, then a column pass.
//  Drives the array's unified command word and the transpose-memory bank swap, and reports busy/done to the host.
//  Sits between the host start/abort interface and the FFT array; it supersedes the free-running single-pass controller.
// PARAMETERS
//  SEQ_MODE_W   4        width of sequence-mode field in unified command (command width = SEQ_MODE_W+2)
//  PASS_CYCLES  647      cycles the array is held in run mode per pass (counter runs 0..PASS_CYCLES-1)
//  GAP_CYCLES   4        idle cycles between row and column pass (transpose bank turnaround), >=1
//  ROW_MODE     4'b0010  sequence mode issued during row pass (FFT-only)
//  COL_MODE     4'b0010  sequence mode issued during column pass (FFT-only)
//  CNT_W        16       width of cycle counter; must hold max(PASS_CYCLES,GAP_CYCLES)-1
// PORTS
//  extc_base_clock    in   1             system clock, all logic on rising edge
//  extc_asyn_reset    in   1             synchronous, active-high reset (sampled on extc_base_clock only)
//  extc_start         in   1             start request; acted on only in IDLE
//  extc_abort         in   1             abort request; returns to IDLE from any state
//  exts_busy          out  1             high while ROW, GAP or COL
//  exts_done          out  1             one-cycle pulse on successful completion of both passes
//  exts_pass_sel      out  1             0 = row pass, 1 = column pass (address-generator select)
//  exts_bank_swap     out  1             one-cycle pulse on first GAP cycle: swap transpose-memory banks
//  f_unified_command  out  SEQ_MODE_W+2  {load, run, mode}; IDLE_CMD={1,0,0}, RUN_CMD={0,1,ROW_MODE|COL_MODE}
// BEHAVIOUR
//  - All outputs registered; no combinational path from inputs to outputs.
//  - Reset (synchronous, wins over everything): state=IDLE, counter=0, exts_busy=0, exts_done=0, exts_pass_sel=0,
//    exts_bank_swap=0, f_unified_command=IDLE_CMD.
//  - States: IDLE, ROW, GAP, COL, DONE.
//  - IDLE: outputs as reset. extc_start=1 && extc_abort=0 -> ROW next cycle; counter=0.
//  - ROW: command=RUN_CMD with ROW_MODE, busy=1, pass_sel=0; counter increments each cycle.
//    At counter==PASS_CYCLES-1 -> GAP, counter=0.
//  - GAP: command=IDLE_CMD, busy=1, pass_sel=1. exts_bank_swap=1 on first GAP cycle only.
//    At counter==GAP_CYCLES-1 -> COL, counter=0.
//  - COL: command=RUN_CMD with COL_MODE, busy=1, pass_sel=1. At counter==PASS_CYCLES-1 -> DONE.
//  - DONE: exactly one cycle; exts_done=1, busy=0, command=IDLE_CMD, pass_sel=0; -> IDLE.
//  - Cycle budget from the start-sampling edge T:
//    ROW T+1..T+PASS_CYCLES, GAP next GAP_CYCLES, COL next PASS_CYCLES, DONE next cycle.
//  - extc_start while not IDLE: ignored; not queued.
//  - extc_start held high: a new run begins in the cycle after DONE returns to IDLE (back-to-back runs allowed).
//  - extc_abort=1 in ROW/GAP/COL/DONE: next cycle IDLE with reset outputs; exts_done not asserted;
//    no bank_swap issued if abort occurs before GAP entry.
//  - extc_abort and extc_start both high in IDLE: abort wins, stay IDLE.
//  - extc_abort on the final COL cycle: abort wins, no DONE.
//  - Counter never wraps; it is cleared on every state transition.
//  - Any unreachable state encoding -> IDLE next cycle.
// TESTING
//  1) Reset held 3 cycles, then released, start=0 -> busy=0, done=0, command=6'b100000 indefinitely.
//  2) Start pulse at T (defaults) -> command=6'b010010 and pass_sel=0 for T+1..T+647; bank_swap=1 at T+648 only;
//     command=6'b100000 T+648..T+651; pass_sel=1, command=6'b010010 T+652..T+1298; done=1 at T+1299 only; busy=0 at T+1299.
//  3) Abort at T+300 (in ROW) -> T+301 IDLE, command=6'b100000, busy=0; no bank_swap, no done ever pulses.
//  4) Start re-pulsed during ROW and COL -> ignored; total busy length still exactly 1298 cycles; single done pulse.
//  5) Start held high continuously -> done at T+1299, next ROW begins T+1301; start+abort together in IDLE -> stays IDLE.
//  6) Synchronous reset asserted at T+700 (mid-COL) -> next edge all outputs at reset values, no done pulse.

Source files
------------

// File: rtl/fft2d_pass_sequencer_if.sv
// fft2d_pass_sequencer_if
//   Host/array-facing signal bundle of the 2D FFT pass sequencer.
//   master : host side (drives start/abort, observes status and command)
//   slave  : sequencer side (receives start/abort, drives status and command)
//   Signals:
//     extc_start, extc_abort        host requests
//     exts_busy, exts_done          host status
//     exts_pass_sel, exts_bank_swap address-generator select / transpose bank swap pulse
//     f_unified_command             {load, run, mode} word to the FFT array
interface fft2d_pass_sequencer_if #(
    parameter int SEQ_MODE_W = 4
) ();
    logic                  extc_start;
    logic                  extc_abort;
    logic                  exts_busy;
    logic                  exts_done;
    logic                  exts_pass_sel;
    logic                  exts_bank_swap;
    logic [SEQ_MODE_W+1:0] f_unified_command;

    modport master (
        output extc_start,
        output extc_abort,
        input  exts_busy,
        input  exts_done,
        input  exts_pass_sel,
        input  exts_bank_swap,
        input  f_unified_command
    );

    modport slave (
        input  extc_start,
        input  extc_abort,
        output exts_busy,
        output exts_done,
        output exts_pass_sel,
        output exts_bank_swap,
        output f_unified_command
    );
endinterface

// File: rtl/fft2d_pass_sequencer.sv
// fft2d_pass_sequencer
//   Sequences one 2D FFT over the 1D FFT array: row pass, transpose bank
//   turnaround gap, column pass, then a single-cycle done.
//   Ports:
//     extc_base_clock  system clock, rising edge
//     extc_asyn_reset  synchronous active-high reset
//     bus (slave)      start/abort in; busy, done, pass_sel, bank_swap and
//                      the unified array command out (all registered)
module fft2d_pass_sequencer #(
    parameter int                    SEQ_MODE_W  = 4,
    parameter int                    PASS_CYCLES = 647,
    parameter int                    GAP_CYCLES  = 4,
    parameter logic [SEQ_MODE_W-1:0] ROW_MODE    = 4'b0010,
    parameter logic [SEQ_MODE_W-1:0] COL_MODE    = 4'b0010,
    parameter int                    CNT_W       = 16
) (
    input  logic                  extc_base_clock,
    input  logic                  extc_asyn_reset,
    fft2d_pass_sequencer_if.slave bus
);

    localparam int CMD_W = SEQ_MODE_W + 2;
    localparam logic [CMD_W-1:0] IDLE_CMD = {1'b1, 1'b0, {SEQ_MODE_W{1'b0}}};
    localparam logic [CMD_W-1:0] ROW_CMD  = {1'b0, 1'b1, ROW_MODE};
    localparam logic [CMD_W-1:0] COL_CMD  = {1'b0, 1'b1, COL_MODE};
    localparam logic [CNT_W-1:0] PASS_LAST = CNT_W'(PASS_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_ROW  = 3'd1,
        ST_GAP  = 3'd2,
        ST_COL  = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               pass_sel_reg, pass_sel_next;
    logic               bank_swap_reg, bank_swap_next;
    logic [CMD_W-1:0]   cmd_reg, cmd_next;

    // Next-state, counter and next-output decode. Outputs are decoded from
    // state_next and registered, so they line up with the state register
    // without any input-to-output combinational path.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);

        case (state_reg)
            ST_IDLE: if (bus.extc_start) state_next = ST_ROW;
            ST_ROW:  if (cnt_reg == PASS_LAST) state_next = ST_GAP;
            ST_GAP:  if (cnt_reg == GAP_LAST)  state_next = ST_COL;
            ST_COL:  if (cnt_reg == PASS_LAST) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase

        // Abort overrides everything, including start in IDLE and the
        // final COL cycle.
        if (bus.extc_abort) begin
            state_next = ST_IDLE;
        end

        // Counter is cleared on every transition and held at zero outside
        // the counted states, so it can never wrap.
        if (state_next != state_reg || state_next == ST_IDLE || state_next == ST_DONE) begin
            cnt_next = '0;
        end

        busy_next      = (state_next == ST_ROW) || (state_next == ST_GAP) || (state_next == ST_COL);
        done_next      = (state_next == ST_DONE);
        pass_sel_next  = (state_next == ST_GAP) || (state_next == ST_COL);
        bank_swap_next = (state_next == ST_GAP) && (state_reg != ST_GAP);

        case (state_next)
            ST_ROW:  cmd_next = ROW_CMD;
            ST_COL:  cmd_next = COL_CMD;
            default: cmd_next = IDLE_CMD;
        endcase
    end

    always_ff @(posedge extc_base_clock) begin
        if (extc_asyn_reset) begin
            state_reg     <= ST_IDLE;
            cnt_reg       <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            pass_sel_reg  <= 1'b0;
            bank_swap_reg <= 1'b0;
            cmd_reg       <= IDLE_CMD;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
            pass_sel_reg  <= pass_sel_next;
            bank_swap_reg <= bank_swap_next;
            cmd_reg       <= cmd_next;
        end
    end

    assign bus.exts_busy         = busy_reg;
    assign bus.exts_done         = done_reg;
    assign bus.exts_pass_sel     = pass_sel_reg;
    assign bus.exts_bank_swap    = bank_swap_reg;
    assign bus.f_unified_command = cmd_reg;

endmodule

// File: tb/tb_fft2d_pass_sequencer.sv
// tb_fft2d_pass_sequencer
//   Directed bench for fft2d_pass_sequencer with default parameters.
//   Outputs are packed per cycle as {busy, done, pass_sel, bank_swap, cmd[5:0]}
//   and compared against a hand-written cycle profile relative to the start
//   sampling edge T (cycle k = T+k).
module tb_fft2d_pass_sequencer;

    localparam logic [9:0] W_IDLE = 10'b0000_100000;
    localparam logic [9:0] W_ROW  = 10'b1000_010010;
    localparam logic [9:0] W_GAP  = 10'b1010_100000;
    localparam logic [9:0] W_SWAP = 10'b1011_100000;
    localparam logic [9:0] W_COL  = 10'b1010_010010;
    localparam logic [9:0] W_DONE = 10'b0100_100000;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    fft2d_pass_sequencer_if #(.SEQ_MODE_W(4)) bus_if ();

    fft2d_pass_sequencer dut (
        .extc_base_clock (clk),
        .extc_asyn_reset (rst),
        .bus             (bus_if)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] status_word();
        return {bus_if.exts_busy, bus_if.exts_done, bus_if.exts_pass_sel,
                bus_if.exts_bank_swap, bus_if.f_unified_command};
    endfunction

    // Expected status in cycle T+k of an undisturbed run.
    function automatic logic [9:0] exp_word(int k);
        if (k >= 1 && k <= 647)         return W_ROW;
        else if (k == 648)              return W_SWAP;
        else if (k >= 649 && k <= 651)  return W_GAP;
        else if (k >= 652 && k <= 1298) return W_COL;
        else if (k == 1299)             return W_DONE;
        else                            return W_IDLE;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses start for one cycle; on return we are in cycle T+1.
    task automatic start_pulse();
        bus_if.extc_start = 1'b1;
        tick();
        bus_if.extc_start = 1'b0;
    endtask

    int busy_cnt;
    int done_cnt;

    initial begin
        rst = 1'b1;
        bus_if.extc_start = 1'b0;
        bus_if.extc_abort = 1'b0;

        // 1) reset held 3 cycles, then idle with start low
        repeat (3) tick();
        check_val("reset_state", 32'(status_word()), 32'(W_IDLE));
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_val("idle_after_reset", 32'(status_word()), 32'(W_IDLE));
            tick();
        end
        $display("txn1 reset/idle done");

        // 2) full nominal run
        start_pulse();
        for (int k = 1; k <= 1302; k++) begin
            check_val($sformatf("run_k%0d", k), 32'(status_word()), 32'(exp_word(k)));
            tick();
        end
        $display("txn2 nominal run done");

        // 3) abort in ROW at T+300
        start_pulse();
        for (int k = 1; k <= 300; k++) begin
            check_val($sformatf("abort_row_k%0d", k), 32'(status_word()), 32'(exp_word(k)));
            if (k == 300) bus_if.extc_abort = 1'b1;
            tick();
        end
        bus_if.extc_abort = 1'b0;
        for (int k = 301; k <= 1310; k++) begin
            check_val($sformatf("after_abort_k%0d", k), 32'(status_word()), 32'(W_IDLE));
            tick();
        end
        $display("txn3 abort in ROW done");

        // 4) start re-pulsed during ROW and COL is ignored
        busy_cnt = 0;
        done_cnt = 0;
        start_pulse();
        for (int k = 1; k <= 1305; k++) begin
            check_val($sformatf("restart_k%0d", k), 32'(status_word()), 32'(exp_word(k)));
            if (bus_if.exts_busy) busy_cnt++;
            if (bus_if.exts_done) done_cnt++;
            bus_if.extc_start = (k == 100 || k == 800);
            tick();
        end
        bus_if.extc_start = 1'b0;
        check_val("busy_len", 32'(busy_cnt), 32'd1298);
        check_val("done_pulses", 32'(done_cnt), 32'd1);
        $display("txn4 ignored restarts done");

        // 5) start held high: back-to-back run, then start+abort together
        bus_if.extc_start = 1'b1;
        tick();
        for (int k = 1; k <= 1300; k++) begin
            check_val($sformatf("held_k%0d", k), 32'(status_word()), 32'(exp_word(k)));
            tick();
        end
        check_val("b2b_row_start", 32'(status_word()), 32'(W_ROW));
        bus_if.extc_abort = 1'b1;
        tick();
        check_val("abort_b2b", 32'(status_word()), 32'(W_IDLE));
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("start_abort_idle", 32'(status_word()), 32'(W_IDLE));
        end
        bus_if.extc_start = 1'b0;
        bus_if.extc_abort = 1'b0;
        tick();
        $display("txn5 held start / start+abort done");

        // 6) synchronous reset mid-COL at T+700
        start_pulse();
        for (int k = 1; k <= 700; k++) begin
            check_val($sformatf("pre_reset_k%0d", k), 32'(status_word()), 32'(exp_word(k)));
            if (k == 700) rst = 1'b1;
            tick();
        end
        check_val("reset_mid_col", 32'(status_word()), 32'(W_IDLE));
        rst = 1'b0;
        for (int i = 0; i < 700; i++) begin
            tick();
            check_val("idle_after_mid_reset", 32'(status_word()), 32'(W_IDLE));
        end
        $display("txn6 reset mid-COL done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
